// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute-stage ALU for the MIPS datapath. Decodes the 4-bit operation code
//   from the ALU control unit, computes result / zero / overflow from two
//   operands, and holds them in a one-entry EX/MEM register with a
//   valid/ready handshake, stall back-pressure and flush.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-high clear of the whole stage
//   in_valid     : upstream (ID/EX) presents an operation
//   in_ready     : stage can take an operation this cycle (combinational)
//   ALUoperation : operation code from ALU control
//   op_a, op_b   : operands (rs value; rt value or sign-extended immediate)
//   dest_in      : destination register index, passed through
//   flush        : drop the held entry and the incoming op (mispredict)
//   out_valid    : result register holds a valid entry
//   out_ready    : downstream (MEM) takes the entry this cycle
//   result       : registered ALU result
//   zero         : registered (result == 0), used for beq
//   overflow     : registered signed overflow (ADD/SUB only)
//   dest_out     : registered destination index
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALUoperation,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              overflow,
  output logic [DEST_W-1:0] dest_out
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_op_e;

  alu_op_e           op;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              slt_bit;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ovf;
  logic              accept;

  logic              valid_q,    valid_d;
  logic [WIDTH-1:0]  result_q,   result_d;
  logic              zero_q,     zero_d;
  logic              overflow_q, overflow_d;
  logic [DEST_W-1:0] dest_q,     dest_d;

  // Codes outside the enum fall to the default arm of the decode below.
  assign op   = alu_op_e'(ALUoperation);
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Signed overflow from operand and result sign bits.
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
  assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

  // True signed less-than: the difference sign is inverted exactly when the
  // subtraction overflowed.
  assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
      OP_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:  alu_res = ~(op_a | op_b);
      default: begin alu_res = '0; alu_ovf = 1'b0; end
    endcase
  end

  // Only combinational output->input path: room exists when empty or draining.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    dest_d     = dest_q;
    if (flush) begin
      // Data registers hold; only the valid bit is killed.
      valid_d = 1'b0;
    end else if (accept) begin
      // Covers simultaneous drain+accept: new entry replaces the old one.
      valid_d    = 1'b1;
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      overflow_d = alu_ovf;
      dest_d     = dest_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset too, not just the valid bit, since
      // they are visible on the outputs and must read 0 after reset.
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      dest_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      dest_q     <= dest_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign dest_out  = dest_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Directed self-checking bench for alu_exec_stage. Inputs change 1 ns after
//   a rising edge; outputs are compared at that same point, after the
//   registers have settled.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int WIDTH  = 32;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        ALUoperation;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [DEST_W-1:0] dest_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              overflow;
  logic [DEST_W-1:0] dest_out;

  int errors = 0;
  int checks = 0;

  alu_exec_stage #(.WIDTH(WIDTH), .DEST_W(DEST_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUoperation (ALUoperation),
    .op_a         (op_a),
    .op_b         (op_b),
    .dest_in      (dest_in),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .dest_out     (dest_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    in_valid     = 1'b1;
    ALUoperation = op;
    op_a         = a;
    op_b         = b;
    dest_in      = d;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(4'b0010, 32'h1, 32'h1, 5'd3);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h expected 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset zero: got %b expected 0", zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", overflow); end
    checks++; if (dest_out !== 5'd0) begin errors++; $display("FAIL reset dest_out: got %0d expected 0", dest_out); end
    reset = 1'b0;
    drive(4'b0010, 32'd5, 32'd7, 5'd9);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pre-accept out_valid: got %b expected 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first add out_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL first add result: got %h expected 0000000c", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL first add zero: got %b expected 0", zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL first add overflow: got %b expected 0", overflow); end
    checks++; if (dest_out !== 5'd9) begin errors++; $display("FAIL first add dest_out: got %0d expected 9", dest_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL drain holds result: got %h expected 0000000c", result); end
  endtask

  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ovf;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v [15];
    v[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1}; // ADD ovf
    v[1]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1}; // SUB ovf
    v[2]  = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0}; // SLT with sub ovf
    v[3]  = '{4'b0111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0}; // SLT false
    v[4]  = '{4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0}; // SLT false, sub ovf
    v[5]  = '{4'b0111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0}; // SLT -2 < -1
    v[6]  = '{4'b0110, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0}; // beq equal
    v[7]  = '{4'b0000, 32'h000000F0, 32'h0000000F, 32'h00000000, 1'b1, 1'b0}; // AND zero
    v[8]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0}; // NOR
    v[9]  = '{4'b0001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0}; // OR
    v[10] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0}; // carry, no ovf
    v[11] = '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1}; // neg+neg ovf
    v[12] = '{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1}; // pos-neg ovf
    v[13] = '{4'b0011, 32'h00000005, 32'h00000007, 32'h00000000, 1'b1, 1'b0}; // undefined code
    v[14] = '{4'b0000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0, 1'b0}; // AND pass
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 5'(i + 1));
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op[%0d] out_valid: got %b expected 1", i, out_valid); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL op[%0d] result: got %h expected %h", i, result, v[i].res); end
      checks++; if (zero !== v[i].z) begin errors++; $display("FAIL op[%0d] zero: got %b expected %b", i, zero, v[i].z); end
      checks++; if (overflow !== v[i].ovf) begin errors++; $display("FAIL op[%0d] overflow: got %b expected %b", i, overflow, v[i].ovf); end
      checks++; if (dest_out !== 5'(i + 1)) begin errors++; $display("FAIL op[%0d] dest_out: got %0d expected %0d", i, dest_out, i + 1); end
    end
    in_valid = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_pressure();
    out_ready = 1'b1;
    drive(4'b0010, 32'd1, 32'd2, 5'd1);
    step();
    checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp load: got valid=%b result=%h expected valid=1 result=00000003", out_valid, result); end
    out_ready = 1'b0;
    drive(4'b0010, 32'd10, 32'd20, 5'd2);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %b expected 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] in_ready: got %b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || result !== 32'd3 || dest_out !== 5'd1)
        begin errors++; $display("FAIL bp[%0d] frozen: got valid=%b result=%h dest=%0d expected valid=1 result=00000003 dest=1", c, out_valid, result, dest_out); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd30 || dest_out !== 5'd2)
      begin errors++; $display("FAIL bp pending op: got valid=%b result=%h dest=%0d expected valid=1 result=0000001e dest=2", out_valid, result, dest_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp no duplicate: got out_valid=%b expected 0", out_valid); end
    checks++; if (result !== 32'd30) begin errors++; $display("FAIL bp drain hold: got %h expected 0000001e", result); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0010, 32'(i), 32'd100, 5'(i + 10));
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream[%0d] out_valid: got %b expected 1", i, out_valid); end
      checks++; if (result !== 32'(i + 100) || dest_out !== 5'(i + 10))
        begin errors++; $display("FAIL stream[%0d] data: got result=%0d dest=%0d expected result=%0d dest=%0d", i, result, dest_out, i + 100, i + 10); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream end out_valid: got %b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    out_ready = 1'b1;
    drive(4'b0010, 32'd1, 32'd1, 5'd3);
    step();
    out_ready = 1'b0;
    drive(4'b0010, 32'd5, 32'd5, 5'd4);
    step();
    checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin errors++; $display("FAIL flush setup: got valid=%b result=%h expected valid=1 result=00000002", out_valid, result); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'd2 || dest_out !== 5'd3)
      begin errors++; $display("FAIL flush hold data: got result=%h dest=%0d expected result=00000002 dest=3", result, dest_out); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || result !== 32'd2) begin errors++; $display("FAIL flush dropped op: got valid=%b result=%h expected valid=0 result=00000002", out_valid, result); end
    // Flush wins over an accept into an empty stage.
    drive(4'b0010, 32'd8, 32'd8, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || result !== 32'd2) begin errors++; $display("FAIL flush beats accept: got valid=%b result=%h expected valid=0 result=00000002", out_valid, result); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_stall();
    out_ready = 1'b1;
    drive(4'b0111, 32'h80000000, 32'd1, 5'd7);
    step();
    out_ready = 1'b0;
    drive(4'b0010, 32'd9, 32'd9, 5'd8);
    step();
    checks++; if (out_valid !== 1'b1 || result !== 32'd1 || dest_out !== 5'd7)
      begin errors++; $display("FAIL rst stall setup: got valid=%b result=%h dest=%0d expected valid=1 result=00000001 dest=7", out_valid, result, dest_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || overflow !== 1'b0 || dest_out !== 5'd0)
      begin errors++; $display("FAIL rst stall clear: got valid=%b result=%h zero=%b ovf=%b dest=%0d expected all 0", out_valid, result, zero, overflow, dest_out); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst stall after: got out_valid=%b expected 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ALUoperation = 4'b0; op_a = '0; op_b = '0; dest_in = '0;
    test_reset();
    test_alu_ops();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU for the MIPS datapath. Sits directly downstream of the ALU control unit and consumes its 4-bit ALU operation code.
- Computes the result, zero flag and overflow flag from two 32-bit operands.
- Registers the outputs in a one-entry EX/MEM pipeline register with valid/ready handshake, stall back-pressure and flush.

Parameters:
WIDTH, 32, operand/result width in bits (the only supported value is 32; the tests use 32)
DEST_W, 5, width of the passed-through destination register index

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; clears the stage on the next rising edge
in_valid  input  1  upstream (ID/EX) presents a valid operation
in_ready  output  1  stage can accept an operation this cycle
ALUoperation  input  4  operation code from the ALU control unit
op_a  input  WIDTH  operand A (rs value)
op_b  input  WIDTH  operand B (rt value or sign-extended immediate)
dest_in  input  DEST_W  destination register index, passed through unchanged
flush  input  1  kill the held entry and the incoming one (branch mispredict)
out_valid  output  1  result register holds a valid entry
out_ready  input  1  downstream (MEM) accepts the entry this cycle
result  output  WIDTH  registered ALU result
zero  output  1  registered (result == 0)
overflow  output  1  registered signed overflow, for add/sub only
dest_out  output  DEST_W  registered destination index

Behaviour:
- Reset: on a rising edge with reset=1, out_valid, result, zero, overflow and dest_out all become 0. Reset overrides every other input. Reset mid-stall discards the held entry.
- in_ready = !out_valid || out_ready. This is combinational and is the only combinational path from output to input.
- Accept: in_valid && in_ready && !flush at a rising edge. On accept:
  - result, zero, overflow and dest_out load the newly computed values.
  - out_valid becomes 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no accept in the same cycle sets out_valid to 0. The data registers keep their old values.
- Simultaneous drain and accept: the new entry replaces the old one in the same cycle, so out_valid stays 1. This gives full throughput of 1 op/cycle.
- Stall: out_valid && !out_ready makes in_ready 0. All registers hold and the upstream op is not consumed.
- Flush: at a rising edge with flush=1 (and reset=0):
  - out_valid becomes 0 and the incoming op is discarded.
  - The data registers hold.
  - Flush takes priority over accept and drain.
- Operation decode (combinational on the op inputs):
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, modulo 2^WIDTH
  - 0110 SUB: a - b, modulo 2^WIDTH
  - 0111 SLT: 1 if signed a < signed b, else 0. Computed from the true sign, so it is correct when a - b overflows.
  - 1100 NOR: ~(a | b)
  - Any other code: result 0, overflow 0. The entry is still accepted normally.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have differing signs and the result sign differs from a.
  - Overflow is 0 for all other operations.
- zero is computed on the 32-bit result for every operation and is used for beq.
- No internal state besides the single register entry. No state machine beyond the valid bit.

Test Plan:
- Reset then ADD: assert reset 2 cycles, then in_valid with op 0010, a=5, b=7, dest 9. Required: out_valid=1 one cycle later with result=12, zero=0, overflow=0, dest_out=9. Before that, all outputs are 0.
- Overflow cases:
  - ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow=1.
  - SUB 0x80000000 - 1 -> result 0x7FFFFFFF, overflow=1.
  - SLT a=0x80000000, b=1 -> result 1.
- beq zero flag: SUB a=b=0x1234 -> result 0, zero=1. AND 0xF0 & 0x0F -> zero=1. NOR 0 with 0 -> 0xFFFFFFFF, zero=0.
- Back-pressure: hold out_ready=0 with an entry valid and in_valid=1 for 3 cycles. Required: in_ready=0 and outputs frozen throughout. When out_ready rises, the pending op is accepted that cycle and appears the next cycle. No op is lost or duplicated.
- Streaming: 8 back-to-back ops with out_ready=1. Required: 8 consecutive out_valid cycles with results in order.
- Flush/reset: flush while an entry is stalled and in_valid=1 -> out_valid=0 next cycle, incoming op dropped. Reset asserted during a stall -> all outputs 0 next cycle.
